multicycle_control: RTL and testbench

Multicycle MIPS main controller: a Moore FSM (Mealy only on `mem_ready`) that sequences a shared-ALU, shared-memory datapath through fetch, decode, execute, memory and writeback. It supports R-type, lw, sw, beq, addi and j, with the same opcodes and ALUOp encoding as the single-cycle/pipelined `control` unit. It waits on a memory-ready handshake and sits between the instruction register and the datapath muxes and enables.

---
 rtl/mc_ctrl_pkg.sv | 55 +++++
 rtl/mc_ctrl_outdec.sv | 73 +++++++
 rtl/multicycle_control.sv | 94 +++++++++
 tb/tb_multicycle_control.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/mc_ctrl_pkg.sv
// rtl/mc_ctrl_pkg.sv - shared encodings for the multicycle MIPS main controller
package mc_ctrl_pkg;

    localparam logic [3:0] S_FETCH  = 4'd0;
    localparam logic [3:0] S_DECODE = 4'd1;
    localparam logic [3:0] S_MEMADR = 4'd2;
    localparam logic [3:0] S_MEMRD  = 4'd3;
    localparam logic [3:0] S_MEMWB  = 4'd4;
    localparam logic [3:0] S_MEMWR  = 4'd5;
    localparam logic [3:0] S_EXEC   = 4'd6;
    localparam logic [3:0] S_ALUWB  = 4'd7;
    localparam logic [3:0] S_BRANCH = 4'd8;
    localparam logic [3:0] S_ADDIEX = 4'd9;
    localparam logic [3:0] S_ADDIWB = 4'd10;
    localparam logic [3:0] S_JUMP   = 4'd11;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_ADDI  = 2'b11;

    localparam logic [1:0] SRCB_REG   = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       instr_done;
    } ctrl_t;

endpackage

// File: rtl/mc_ctrl_outdec.sv
// rtl/mc_ctrl_outdec.sv - combinational decode of (state, mem_ready) to datapath controls
module mc_ctrl_outdec
    import mc_ctrl_pkg::*;
(
    input  logic [3:0] state,
    input  logic       mem_ready,
    output ctrl_t      ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                // IR/PC capture only in the cycle the read actually completes
                ctrl.ir_write  = mem_ready;
                ctrl.pc_write  = mem_ready;
            end
            S_DECODE: ctrl.alu_src_b = SRCB_IMMSH;
            S_MEMADR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
            end
            S_MEMRD: begin
                ctrl.iord     = 1'b1;
                ctrl.mem_read = 1'b1;
            end
            S_MEMWB: begin
                ctrl.mem_to_reg = 1'b1;
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_MEMWR: begin
                ctrl.iord       = 1'b1;
                ctrl.mem_write  = 1'b1;
                ctrl.instr_done = mem_ready;
            end
            S_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_op    = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                ctrl.reg_dst    = 1'b1;
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_op        = ALUOP_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PCSRC_ALUOUT;
                ctrl.instr_done    = 1'b1;
            end
            S_ADDIEX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADDI;
            end
            S_ADDIWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_JUMP: begin
                ctrl.pc_write   = 1'b1;
                ctrl.pc_source  = PCSRC_JUMP;
                ctrl.instr_done = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multicycle MIPS main controller: state register and sequencing
module multicycle_control
    import mc_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemtoReg,
    output logic       RegDst,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] PCSource,
    output logic       instr_done,
    output logic       illegal_op,
    output logic [3:0] state
);

    logic [3:0] state_q;
    logic [3:0] state_d;
    logic       op_legal;
    ctrl_t      dec;
    ctrl_t      ctrl;

    mc_ctrl_outdec u_outdec (
        .state     (state_q),
        .mem_ready (mem_ready),
        .ctrl      (dec)
    );

    always_comb begin
        op_legal = 1'b1;
        state_d  = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXEC;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JUMP;
                    default: begin
                        state_d  = S_FETCH;
                        op_legal = 1'b0;
                    end
                endcase
            end
            S_MEMADR: state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  state_d = mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWR:  state_d = mem_ready ? S_FETCH : S_MEMWR;
            S_EXEC:   state_d = S_ALUWB;
            S_ADDIEX: state_d = S_ADDIWB;
            default:  state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Reset gates outputs directly so FETCH's MemRead does not escape while held in reset
    assign ctrl = rst_n ? dec : '0;

    assign PCWrite     = ctrl.pc_write;
    assign PCWriteCond = ctrl.pc_write_cond;
    assign IorD        = ctrl.iord;
    assign MemRead     = ctrl.mem_read;
    assign MemWrite    = ctrl.mem_write;
    assign IRWrite     = ctrl.ir_write;
    assign MemtoReg    = ctrl.mem_to_reg;
    assign RegDst      = ctrl.reg_dst;
    assign RegWrite    = ctrl.reg_write;
    assign ALUSrcA     = ctrl.alu_src_a;
    assign ALUSrcB     = ctrl.alu_src_b;
    assign ALUOp       = ctrl.alu_op;
    assign PCSource    = ctrl.pc_source;
    assign instr_done  = ctrl.instr_done;
    assign illegal_op  = rst_n & (state_q == S_DECODE) & ~op_legal;
    assign state       = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - table-driven bench for multicycle_control
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic       MemtoReg, RegDst, RegWrite, ALUSrcA;
    logic [1:0] ALUSrcB, ALUOp, PCSource;
    logic       instr_done, illegal_op;
    logic [3:0] state;

    int checks = 0;
    int errors = 0;

    multicycle_control dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .opcode      (opcode),
        .mem_ready   (mem_ready),
        .PCWrite     (PCWrite),
        .PCWriteCond (PCWriteCond),
        .IorD        (IorD),
        .MemRead     (MemRead),
        .MemWrite    (MemWrite),
        .IRWrite     (IRWrite),
        .MemtoReg    (MemtoReg),
        .RegDst      (RegDst),
        .RegWrite    (RegWrite),
        .ALUSrcA     (ALUSrcA),
        .ALUSrcB     (ALUSrcB),
        .ALUOp       (ALUOp),
        .PCSource    (PCSource),
        .instr_done  (instr_done),
        .illegal_op  (illegal_op),
        .state       (state)
    );

    always #5 clk = ~clk;

    // flags: PCWrite,PCWriteCond,IorD,MemRead,MemWrite,IRWrite,MemtoReg,RegDst,RegWrite,ALUSrcA
    typedef struct {
        string      name;
        logic       rst_n;
        logic [5:0] opcode;
        logic       mem_ready;
        logic [3:0] exp_state;
        logic [17:0] exp_out;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [17:0] outs();
        return {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
                RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, instr_done, illegal_op};
    endfunction

    task automatic add(input string name, input logic r, input logic [5:0] op,
                       input logic mr, input logic [3:0] st, input logic [9:0] flags,
                       input logic [1:0] srcb, input logic [1:0] aluop,
                       input logic [1:0] pcsrc, input logic done, input logic ill);
        vec_t v;
        v.name = name; v.rst_n = r; v.opcode = op; v.mem_ready = mr;
        v.exp_state = st;
        v.exp_out = {flags, srcb, aluop, pcsrc, done, ill};
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [3:0] st, input logic [17:0] ex);
        checks++;
        if (state !== st) begin
            errors++;
            $display("FAIL %s state: got %0d expected %0d", name, state, st);
        end
        checks++;
        if (outs() !== ex) begin
            errors++;
            $display("FAIL %s outputs: got %b expected %b", name, outs(), ex);
        end
    endtask

    task automatic apply(input vec_t v);
        @(negedge clk);
        rst_n = v.rst_n; opcode = v.opcode; mem_ready = v.mem_ready;
        #1;
        check(v.name, v.exp_state, v.exp_out);
    endtask

    localparam logic [9:0] F_FETCH  = 10'b1001010000;
    localparam logic [9:0] F_FWAIT  = 10'b0001000000;
    localparam logic [9:0] F_NONE   = 10'b0000000000;
    localparam logic [9:0] F_SRCA   = 10'b0000000001;
    localparam logic [9:0] F_MEMRD  = 10'b0011000000;
    localparam logic [9:0] F_MEMWB  = 10'b0000001010;
    localparam logic [9:0] F_MEMWR  = 10'b0010100000;
    localparam logic [9:0] F_ALUWB  = 10'b0000000110;
    localparam logic [9:0] F_BRANCH = 10'b0100000001;
    localparam logic [9:0] F_JUMP   = 10'b1000000000;
    localparam logic [9:0] F_REGWR  = 10'b0000000010;

    initial begin
        rst_n = 1'b0; opcode = 6'b0; mem_ready = 1'b1;

        add("reset",      0, 6'b100011, 1, 0, F_NONE,   2'b00, 2'b00, 2'b00, 0, 0);
        // lw, mem_ready always 1: 5 cycles
        add("lw_fetch",   1, 6'b100011, 1, 0, F_FETCH,  2'b01, 2'b00, 2'b00, 0, 0);
        add("lw_decode",  1, 6'b100011, 1, 1, F_NONE,   2'b11, 2'b00, 2'b00, 0, 0);
        add("lw_memadr",  1, 6'b100011, 1, 2, F_SRCA,   2'b10, 2'b00, 2'b00, 0, 0);
        add("lw_memrd",   1, 6'b000100, 1, 3, F_MEMRD,  2'b00, 2'b00, 2'b00, 0, 0);
        add("lw_memwb",   1, 6'b000100, 1, 4, F_MEMWB,  2'b00, 2'b00, 2'b00, 1, 0);
        // sw with two wait cycles in MEMWR: 6 cycles
        add("sw_fetch",   1, 6'b101011, 1, 0, F_FETCH,  2'b01, 2'b00, 2'b00, 0, 0);
        add("sw_decode",  1, 6'b101011, 0, 1, F_NONE,   2'b11, 2'b00, 2'b00, 0, 0);
        add("sw_memadr",  1, 6'b101011, 1, 2, F_SRCA,   2'b10, 2'b00, 2'b00, 0, 0);
        add("sw_wait1",   1, 6'b101011, 0, 5, F_MEMWR,  2'b00, 2'b00, 2'b00, 0, 0);
        add("sw_wait2",   1, 6'b000000, 0, 5, F_MEMWR,  2'b00, 2'b00, 2'b00, 0, 0);
        add("sw_done",    1, 6'b000000, 1, 5, F_MEMWR,  2'b00, 2'b00, 2'b00, 1, 0);
        // R-type: 4 cycles
        add("r_fetch",    1, 6'b000000, 1, 0, F_FETCH,  2'b01, 2'b00, 2'b00, 0, 0);
        add("r_decode",   1, 6'b000000, 1, 1, F_NONE,   2'b11, 2'b00, 2'b00, 0, 0);
        add("r_exec",     1, 6'b100011, 1, 6, F_SRCA,   2'b00, 2'b10, 2'b00, 0, 0);
        add("r_aluwb",    1, 6'b100011, 1, 7, F_ALUWB,  2'b00, 2'b00, 2'b00, 1, 0);
        // beq: 3 cycles
        add("beq_fetch",  1, 6'b000100, 1, 0, F_FETCH,  2'b01, 2'b00, 2'b00, 0, 0);
        add("beq_decode", 1, 6'b000100, 1, 1, F_NONE,   2'b11, 2'b00, 2'b00, 0, 0);
        add("beq_branch", 1, 6'b000100, 1, 8, F_BRANCH, 2'b00, 2'b01, 2'b01, 1, 0);
        // j: 3 cycles
        add("j_fetch",    1, 6'b000010, 1, 0, F_FETCH,  2'b01, 2'b00, 2'b00, 0, 0);
        add("j_decode",   1, 6'b000010, 1, 1, F_NONE,   2'b11, 2'b00, 2'b00, 0, 0);
        add("j_jump",     1, 6'b000010, 1, 11, F_JUMP,  2'b00, 2'b00, 2'b10, 1, 0);
        // addi: 4 cycles
        add("addi_fetch", 1, 6'b001000, 1, 0, F_FETCH,  2'b01, 2'b00, 2'b00, 0, 0);
        add("addi_dec",   1, 6'b001000, 1, 1, F_NONE,   2'b11, 2'b00, 2'b00, 0, 0);
        add("addi_ex",    1, 6'b001000, 1, 9, F_SRCA,   2'b10, 2'b11, 2'b00, 0, 0);
        add("addi_wb",    1, 6'b001000, 1, 10, F_REGWR, 2'b00, 2'b00, 2'b00, 1, 0);
        // illegal opcode: 2 cycles, then FETCH waiting on memory
        add("ill_fetch",  1, 6'b111111, 1, 0, F_FETCH,  2'b01, 2'b00, 2'b00, 0, 0);
        add("ill_decode", 1, 6'b111111, 1, 1, F_NONE,   2'b11, 2'b00, 2'b00, 0, 1);
        add("fetch_wt1",  1, 6'b111111, 0, 0, F_FWAIT,  2'b01, 2'b00, 2'b00, 0, 0);
        add("fetch_wt2",  1, 6'b100011, 0, 0, F_FWAIT,  2'b01, 2'b00, 2'b00, 0, 0);
        // lw with a wait in MEMRD
        add("lw2_fetch",  1, 6'b100011, 1, 0, F_FETCH,  2'b01, 2'b00, 2'b00, 0, 0);
        add("lw2_decode", 1, 6'b100011, 1, 1, F_NONE,   2'b11, 2'b00, 2'b00, 0, 0);
        add("lw2_memadr", 1, 6'b100011, 1, 2, F_SRCA,   2'b10, 2'b00, 2'b00, 0, 0);
        add("lw2_rdwait", 1, 6'b101011, 0, 3, F_MEMRD,  2'b00, 2'b00, 2'b00, 0, 0);
        add("lw2_memrd",  1, 6'b101011, 1, 3, F_MEMRD,  2'b00, 2'b00, 2'b00, 0, 0);
        add("lw2_memwb",  1, 6'b101011, 0, 4, F_MEMWB,  2'b00, 2'b00, 2'b00, 1, 0);
        add("back_fetch", 1, 6'b100011, 1, 0, F_FETCH,  2'b01, 2'b00, 2'b00, 0, 0);

        foreach (vecs[i]) apply(vecs[i]);

        // Now in DECODE of lw; step into MEMRD, then drop reset mid-cycle
        @(negedge clk); opcode = 6'b100011; mem_ready = 1'b1;
        @(negedge clk);
        @(negedge clk); mem_ready = 1'b0;
        #1 check("pre_reset_memrd", 4'd3, {F_MEMRD, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0});
        #1 rst_n = 1'b0;
        #1 check("async_reset", 4'd0, 18'b0);
        mem_ready = 1'b1;
        @(negedge clk);
        #1 check("held_reset", 4'd0, 18'b0);
        @(negedge clk); rst_n = 1'b1; mem_ready = 1'b0;
        #1 check("release_wait", 4'd0, {F_FWAIT, 2'b01, 2'b00, 2'b00, 1'b0, 1'b0});
        @(negedge clk);
        #1 check("release_hold", 4'd0, {F_FWAIT, 2'b01, 2'b00, 2'b00, 1'b0, 1'b0});
        mem_ready = 1'b1;
        #1 check("release_fetch", 4'd0, {F_FETCH, 2'b01, 2'b00, 2'b00, 1'b0, 1'b0});
        @(negedge clk);
        #1 check("after_fetch", 4'd1, {F_NONE, 2'b11, 2'b00, 2'b00, 1'b0, 1'b0});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
